// File: rtl/block_sync_seeker_pkg.sv
// Shared constants, FSM state type and header check for the 64b/66b block sync seeker.
package seeker_pkg;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CMD  = 2'b10;
   localparam int         WIN_W    = 67;
   localparam int         N_CAND   = 66;
   localparam int         BUF_W    = 194;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } seek_state_t;

   function automatic logic hdr_valid(input logic [1:0] hdr);
      return (hdr == HDR_DATA) || (hdr == HDR_CMD);
   endfunction

endpackage

// File: rtl/block_sync_seeker_if.sv
// Gearbox-side bus and lock status of the block sync seeker.
// SEEKER_STATS_EN adds the lock_loss_cnt_o statistics signal.
interface block_sync_seeker_if;
   import seeker_pkg::*;

   logic [BUF_W-1:0] gbox_buffer;
   logic [5:0]       gbox_cnt;
   logic             buffer_dv;
   logic [6:0]       block_offset;
   logic             locked_o;
   logic             lock_lost_o;

`ifdef SEEKER_STATS_EN
   logic [15:0]      lock_loss_cnt_o;

   modport master (
      output gbox_buffer, gbox_cnt, buffer_dv,
      input  block_offset, locked_o, lock_lost_o, lock_loss_cnt_o
   );
   modport slave (
      input  gbox_buffer, gbox_cnt, buffer_dv,
      output block_offset, locked_o, lock_lost_o, lock_loss_cnt_o
   );
`else
   modport master (
      output gbox_buffer, gbox_cnt, buffer_dv,
      input  block_offset, locked_o, lock_lost_o
   );
   modport slave (
      input  gbox_buffer, gbox_cnt, buffer_dv,
      output block_offset, locked_o, lock_lost_o
   );
`endif

endinterface

// File: rtl/block_sync_seeker_argmax.sv
// Two-stage registered max tree over hunter counts; ties go to the lowest hunter index.
module seeker_argmax
   import seeker_pkg::*;
#(
   parameter int N_SEEKERS = 11,
   parameter int CNT_W     = 6
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  logic [N_SEEKERS-1:0][CNT_W-1:0]      cnt_i,
   input  logic [N_SEEKERS-1:0][6:0]            off_i,
   output logic [CNT_W-1:0]                     best_cnt,
   output logic [6:0]                           best_off
);

   localparam int N_GRP = (N_SEEKERS + 3) / 4;

   logic [N_GRP-1:0][CNT_W-1:0] grp_cnt_s;
   logic [N_GRP-1:0][6:0]       grp_off_s;
   logic [N_GRP-1:0][CNT_W-1:0] grp_cnt_r;
   logic [N_GRP-1:0][6:0]       grp_off_r;
   logic [CNT_W-1:0]            top_cnt_s;
   logic [6:0]                  top_off_s;

   // Stage 1: best of each group of up to four hunters (strict > keeps the lower index).
   always_comb begin : stage1_max
      int   idx;
      logic take;
      for (int g = 0; g < N_GRP; g++) begin
         grp_cnt_s[g] = cnt_i[g*4];
         grp_off_s[g] = off_i[g*4];
         for (int k = 1; k < 4; k++) begin
            idx  = ((g*4 + k) < N_SEEKERS) ? (g*4 + k) : (N_SEEKERS - 1);
            take = ((g*4 + k) < N_SEEKERS) && (cnt_i[idx] > grp_cnt_s[g]);
            grp_cnt_s[g] = take ? cnt_i[idx] : grp_cnt_s[g];
            grp_off_s[g] = take ? off_i[idx] : grp_off_s[g];
         end
      end
   end

   // Stage 2: best across the registered group winners.
   always_comb begin : stage2_max
      logic take;
      top_cnt_s = grp_cnt_r[0];
      top_off_s = grp_off_r[0];
      for (int g = 1; g < N_GRP; g++) begin
         take      = grp_cnt_r[g] > top_cnt_s;
         top_cnt_s = take ? grp_cnt_r[g] : top_cnt_s;
         top_off_s = take ? grp_off_r[g] : top_off_s;
      end
   end

   // Pipeline registers; a flush drops stale results when the hunters are wiped on unlock.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         grp_cnt_r <= '0;
         grp_off_r <= '0;
         best_cnt  <= '0;
         best_off  <= 7'd0;
      end else begin
         grp_cnt_r <= grp_cnt_s;
         grp_off_r <= grp_off_s;
         best_cnt  <= top_cnt_s;
         best_off  <= top_off_s;
      end
   end

endmodule

// File: rtl/block_sync_seeker.sv
// 64b/66b block-header alignment seeker: parallel hunters, pipelined argmax, HUNT/LOCKED tracking.
// Defining SEEKER_STATS_EN adds a saturating 16-bit lock-loss counter output.
module block_sync_seeker
   import seeker_pkg::*;
#(
   parameter int N_SEEKERS   = 11,
   parameter int CNT_W       = 6,
   parameter int LOCK_THRESH = 32,
   parameter int FRAME_LEN   = 64,
   parameter int BAD_THRESH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   block_sync_seeker_if.slave   sif
);

   localparam int P     = N_CAND / N_SEEKERS;
   localparam int POS_W = (P > 1) ? $clog2(P) : 1;
   localparam int FRM_W = $clog2(FRAME_LEN);
   localparam int BAD_W = $clog2(BAD_THRESH + 1);

   logic [7:0]                        win_base_s;
   logic [WIN_W-1:0]                  win_r;
   logic                              win_vld_r;
   logic [N_SEEKERS-1:0][CNT_W-1:0]   hcnt_r;
   logic [N_SEEKERS-1:0][POS_W-1:0]   hpos_r;
   logic [N_SEEKERS-1:0][6:0]         hoff_s;
   logic [N_SEEKERS-1:0]              hvld_s;
   logic [CNT_W-1:0]                  best_cnt_s;
   logic [6:0]                        best_off_s;
   seek_state_t                       state_r;
   logic [6:0]                        blk_off_r;
   logic                              locked_r;
   logic                              lost_r;
   logic [FRM_W-1:0]                  frame_cnt_r;
   logic [BAD_W-1:0]                  bad_cnt_r;
   logic [BAD_W-1:0]                  bad_nxt_s;
   logic                              lock_hdr_ok_s;
   logic                              unlock_s;

   assign win_base_s    = 8'd193 - {2'b00, sif.gbox_cnt};
   assign lock_hdr_ok_s = hdr_valid(win_r[blk_off_r +: 2]);
   assign bad_nxt_s     = bad_cnt_r + (lock_hdr_ok_s ? BAD_W'(0) : BAD_W'(1));
   assign unlock_s      = (state_r == LOCKED) && (bad_cnt_r >= BAD_W'(BAD_THRESH));

   // Window capture from the gearbox buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_r     <= '0;
         win_vld_r <= 1'b0;
      end else if (sif.buffer_dv) begin
         win_r     <= sif.gbox_buffer[win_base_s -: WIN_W];
         win_vld_r <= 1'b1;
      end else begin
         win_vld_r <= 1'b0;
      end
   end

   // Candidate offset and header check for every hunter.
   always_comb begin
      for (int j = 0; j < N_SEEKERS; j++) begin
         hoff_s[j] = 7'(hpos_r[j]) * 7'(N_SEEKERS) + 7'(j);
         hvld_s[j] = hdr_valid(win_r[hoff_s[j] +: 2]);
      end
   end

   // Hunters: count consecutive valid headers, step to the next candidate on a miss.
   always_ff @(posedge clk_i) begin
      if (rst_i || unlock_s) begin
         hcnt_r <= '0;
         hpos_r <= '0;
      end else if (win_vld_r) begin
         for (int j = 0; j < N_SEEKERS; j++) begin
            if (hvld_s[j]) begin
               hcnt_r[j] <= (hcnt_r[j] == {CNT_W{1'b1}}) ? hcnt_r[j] : hcnt_r[j] + CNT_W'(1);
            end else begin
               hcnt_r[j] <= '0;
               hpos_r[j] <= (hpos_r[j] == POS_W'(P - 1)) ? '0 : hpos_r[j] + POS_W'(1);
            end
         end
      end else begin
         hcnt_r <= hcnt_r;
      end
   end

   seeker_argmax #(
      .N_SEEKERS (N_SEEKERS),
      .CNT_W     (CNT_W)
   ) u_argmax (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (unlock_s),
      .cnt_i     (hcnt_r),
      .off_i     (hoff_s),
      .best_cnt  (best_cnt_s),
      .best_off  (best_off_s)
   );

   // Lock FSM; an unlock that coincides with the frame end keeps bad_cnt so it still fires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= HUNT;
         blk_off_r   <= 7'd0;
         locked_r    <= 1'b0;
         lost_r      <= 1'b0;
         frame_cnt_r <= '0;
         bad_cnt_r   <= '0;
      end else begin
         case (state_r)
            HUNT: begin
               lost_r      <= 1'b0;
               frame_cnt_r <= '0;
               bad_cnt_r   <= '0;
               if (best_cnt_s >= CNT_W'(LOCK_THRESH)) begin
                  state_r   <= LOCKED;
                  blk_off_r <= best_off_s;
                  locked_r  <= 1'b1;
               end else begin
                  locked_r  <= 1'b0;
               end
            end
            LOCKED: begin
               if (unlock_s) begin
                  state_r     <= HUNT;
                  locked_r    <= 1'b0;
                  lost_r      <= 1'b1;
                  frame_cnt_r <= '0;
                  bad_cnt_r   <= '0;
               end else if (win_vld_r) begin
                  locked_r <= 1'b1;
                  lost_r   <= 1'b0;
                  if (frame_cnt_r == FRM_W'(FRAME_LEN - 1)) begin
                     frame_cnt_r <= '0;
                     bad_cnt_r   <= (bad_nxt_s >= BAD_W'(BAD_THRESH)) ? bad_nxt_s : '0;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + FRM_W'(1);
                     bad_cnt_r   <= bad_nxt_s;
                  end
               end else begin
                  locked_r <= 1'b1;
                  lost_r   <= 1'b0;
               end
            end
            default: begin
               state_r     <= HUNT;
               locked_r    <= 1'b0;
               lost_r      <= 1'b0;
               frame_cnt_r <= '0;
               bad_cnt_r   <= '0;
            end
         endcase
      end
   end

   assign sif.block_offset = blk_off_r;
   assign sif.locked_o     = locked_r;
   assign sif.lock_lost_o  = lost_r;

`ifdef SEEKER_STATS_EN
   logic [15:0] loss_cnt_r;

   // Saturating count of lock losses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         loss_cnt_r <= 16'd0;
      end else if (unlock_s && (loss_cnt_r != 16'hFFFF)) begin
         loss_cnt_r <= loss_cnt_r + 16'd1;
      end else begin
         loss_cnt_r <= loss_cnt_r;
      end
   end

   assign sif.lock_loss_cnt_o = loss_cnt_r;
`endif

endmodule
